// File: rtl/ee457_mem_arbiter.sv
// ee457_mem_arbiter: two-port request sequencer for the single-port ee457_mem.
// Define EE457_MEM_ARB_RR_EN for round-robin ties; default is port-0 priority.
module ee457_mem_arbiter #(
   parameter int ADDR_SIZE = 8,
   parameter int DATA_SIZE = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req0,
   input  logic                 req1,
   input  logic                 we0,
   input  logic                 we1,
   input  logic [ADDR_SIZE-1:0] addr0,
   input  logic [ADDR_SIZE-1:0] addr1,
   input  logic [DATA_SIZE-1:0] wdata0,
   input  logic [DATA_SIZE-1:0] wdata1,
   output logic                 ack0,
   output logic                 ack1,
   output logic [DATA_SIZE-1:0] rdata0,
   output logic [DATA_SIZE-1:0] rdata1,
   output logic [ADDR_SIZE-1:0] mem_addr,
   output logic [DATA_SIZE-1:0] mem_wdata,
   output logic                 mem_read,
   output logic                 mem_write,
   input  logic [DATA_SIZE-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t                 state_q;
   logic                   win_q;
   logic                   last_grant_q;
   logic                   ack0_q;
   logic                   ack1_q;
   logic [DATA_SIZE-1:0]   rdata0_q;
   logic [DATA_SIZE-1:0]   rdata1_q;
   logic [ADDR_SIZE-1:0]   mem_addr_q;
   logic [DATA_SIZE-1:0]   mem_wdata_q;
   logic                   mem_read_q;
   logic                   mem_write_q;

   logic                   grant_d;
   logic                   any_req_d;
   logic                   we_d;
   logic [ADDR_SIZE-1:0]   addr_d;
   logic [DATA_SIZE-1:0]   wdata_d;

   // With no request the grant simply parks on the last winner.
   always_comb begin
      grant_d   = last_grant_q;
      any_req_d = req0 | req1;
      if (req0 && req1) begin
`ifdef EE457_MEM_ARB_RR_EN
         grant_d = ~last_grant_q;
`else
         grant_d = 1'b0;
`endif
      end else if (req0) begin
         grant_d = 1'b0;
      end else if (req1) begin
         grant_d = 1'b1;
      end
      we_d    = grant_d ? we1    : we0;
      addr_d  = grant_d ? addr1  : addr0;
      wdata_d = grant_d ? wdata1 : wdata0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         win_q        <= 1'b0;
         last_grant_q <= 1'b1;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
      end else begin
         ack0_q <= 1'b0;
         ack1_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               win_q <= grant_d;
               if (any_req_d) begin
                  mem_addr_q  <= addr_d;
                  mem_wdata_q <= wdata_d;
                  mem_read_q  <= ~we_d;
                  mem_write_q <= we_d;
                  state_q     <= ACCESS;
               end else begin
                  mem_read_q  <= 1'b0;
                  mem_write_q <= 1'b0;
               end
            end
            ACCESS: begin
               // mem_rdata is only meaningful while we drive mem_read.
               if (mem_read_q) begin
                  if (win_q) rdata1_q <= mem_rdata;
                  else       rdata0_q <= mem_rdata;
               end
               if (win_q) ack1_q <= 1'b1;
               else       ack0_q <= 1'b1;
               mem_read_q  <= 1'b0;
               mem_write_q <= 1'b0;
               state_q     <= RESP;
            end
            RESP: begin
               last_grant_q <= win_q;
               state_q      <= IDLE;
            end
            default: begin
               mem_read_q  <= 1'b0;
               mem_write_q <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign ack0      = ack0_q;
   assign ack1      = ack1_q;
   assign rdata0    = rdata0_q;
   assign rdata1    = rdata1_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;

endmodule

// File: tb/tb_ee457_mem_arbiter.sv
// tb_ee457_mem_arbiter: randomized bench with a transaction-level memory model.
// Honours EE457_MEM_ARB_RR_EN the same way the design does.
module tb_ee457_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0, req1, we0, we1;
   logic [7:0]  addr0, addr1;
   logic [31:0] wdata0, wdata1;
   logic        ack0, ack1;
   logic [31:0] rdata0, rdata1;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_read, mem_write;
   wire  [31:0] mem_rdata;

   logic [31:0] tb_mem [256];

   logic [31:0] ref_mem [256];
   logic [31:0] ref_rd [2];
   bit          ref_lg;
   logic [7:0]  wlist [$];

   int errors = 0;
   int checks = 0;

   ee457_mem_arbiter #(.ADDR_SIZE(8), .DATA_SIZE(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1),
      .rdata0(rdata0), .rdata1(rdata1),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem_read ? tb_mem[mem_addr] : 'z;

   always @(posedge clk)
      if (mem_write === 1'b1) tb_mem[mem_addr] <= mem_wdata;

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         checks++;
         if (mem_read === 1'b1 && mem_write === 1'b1) begin
            errors++;
            $display("FAIL rw_exclusive: read=%b write=%b want not both",
                     mem_read, mem_write);
         end
      end
   end

   function automatic int tie_winner();
`ifdef EE457_MEM_ARB_RR_EN
      return ref_lg ? 0 : 1;
`else
      return 0;
`endif
   endfunction

   function automatic logic ack_of(input int p);
      return (p == 1) ? ack1 : ack0;
   endfunction

   task automatic set_req(input int p, input logic w,
                          input logic [7:0] a, input logic [31:0] d);
      if (p == 0) begin
         req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
      end else begin
         req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
      end
   endtask

   task automatic drop(input int p);
      if (p == 0) req0 = 1'b0;
      else        req1 = 1'b0;
   endtask

   task automatic model_apply(input int p, input logic w,
                              input logic [7:0] a, input logic [31:0] d);
      if (w) begin
         ref_mem[a] = d;
         wlist.push_back(a);
      end else begin
         ref_rd[p] = ref_mem[a];
      end
      ref_lg = (p == 1);
   endtask

   task automatic run_single(input int p, input logic w,
                             input logic [7:0] a, input logic [31:0] d,
                             input bit early);
      int o = 1 - p;
      @(posedge clk); #1;
      set_req(p, w, a, d);
      @(posedge clk); #1;
      checks++;
      if (mem_read !== ~w || mem_write !== w || mem_addr !== a ||
          (w && mem_wdata !== d) || ack0 !== 1'b0 || ack1 !== 1'b0) begin
         errors++;
         $display("FAIL access_%0d: rd=%b wr=%b addr=%h wd=%h ack=%b%b want rd=%b wr=%b addr=%h",
                  p, mem_read, mem_write, mem_addr, mem_wdata, ack1, ack0, ~w, w, a);
      end
      if (early) drop(p);
      @(posedge clk); #1;
      model_apply(p, w, a, d);
      checks++;
      if (ack_of(p) !== 1'b1 || ack_of(o) !== 1'b0 ||
          mem_read !== 1'b0 || mem_write !== 1'b0) begin
         errors++;
         $display("FAIL ack_%0d: ack=%b other=%b rd=%b wr=%b want 1 0 0 0",
                  p, ack_of(p), ack_of(o), mem_read, mem_write);
      end
      checks++;
      if (rdata0 !== ref_rd[0] || rdata1 !== ref_rd[1] ||
          tb_mem[a] !== ref_mem[a]) begin
         errors++;
         $display("FAIL data_%0d: rd0=%h rd1=%h mem=%h want %h %h %h",
                  p, rdata0, rdata1, tb_mem[a], ref_rd[0], ref_rd[1], ref_mem[a]);
      end
      drop(p);
      @(posedge clk); #1;
      checks++;
      if (ack0 !== 1'b0 || ack1 !== 1'b0) begin
         errors++;
         $display("FAIL ack_pulse_%0d: ack1=%b ack0=%b want 0 0", p, ack1, ack0);
      end
   endtask

   task automatic run_pair(input logic w0, input logic [7:0] a0,
                           input logic [31:0] d0, input logic w1,
                           input logic [7:0] a1, input logic [31:0] d1);
      int          f;
      int          s;
      logic        w [2];
      logic [7:0]  a [2];
      logic [31:0] d [2];
      w[0] = w0; a[0] = a0; d[0] = d0;
      w[1] = w1; a[1] = a1; d[1] = d1;
      f = tie_winner();
      s = 1 - f;
      @(posedge clk); #1;
      set_req(0, w0, a0, d0);
      set_req(1, w1, a1, d1);
      for (int k = 0; k < 2; k++) begin
         int p = (k == 0) ? f : s;
         int o = 1 - p;
         @(posedge clk); #1;
         checks++;
         if (mem_addr !== a[p] || mem_write !== w[p] || mem_read !== ~w[p]) begin
            errors++;
            $display("FAIL pair_grant_%0d: addr=%h wr=%b want addr=%h wr=%b (port %0d)",
                     k, mem_addr, mem_write, a[p], w[p], p);
         end
         @(posedge clk); #1;
         model_apply(p, w[p], a[p], d[p]);
         checks++;
         if (ack_of(p) !== 1'b1 || ack_of(o) !== 1'b0) begin
            errors++;
            $display("FAIL pair_ack_%0d: ack%0d=%b ack%0d=%b want 1 0",
                     k, p, ack_of(p), o, ack_of(o));
         end
         checks++;
         if (rdata0 !== ref_rd[0] || rdata1 !== ref_rd[1]) begin
            errors++;
            $display("FAIL pair_rdata_%0d: rd0=%h rd1=%h want %h %h",
                     k, rdata0, rdata1, ref_rd[0], ref_rd[1]);
         end
         drop(p);
         @(posedge clk); #1;
         checks++;
         if (ack0 !== 1'b0 || ack1 !== 1'b0 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL pair_idle_%0d: ack1=%b ack0=%b wr=%b want 0",
                     k, ack1, ack0, mem_write);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
      ref_rd[0] = 0; ref_rd[1] = 0; ref_lg = 1'b1;
      #12;
      checks++;
      if (mem_addr !== 8'h0 || mem_wdata !== 32'h0 || mem_read !== 1'b0 ||
          mem_write !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0 ||
          rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
         errors++;
         $display("FAIL reset: addr=%h wd=%h rd=%b wr=%b ack=%b%b r0=%h r1=%h want 0",
                  mem_addr, mem_wdata, mem_read, mem_write, ack1, ack0, rdata0, rdata1);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_write_read();
      run_single(0, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0);
      run_single(0, 1'b0, 8'h10, 32'h0, 1'b0);
      checks++;
      if (rdata0 !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL write_read: rdata0=%h want deadbeef", rdata0);
      end
   endtask

   task automatic test_contention();
      int exp_p;
      run_single(1, 1'b1, 8'h01, $urandom, 1'b0);
      run_single(0, 1'b1, 8'h02, $urandom, 1'b0);
      @(posedge clk); #1;
      set_req(0, 1'b0, 8'h01, 32'h0);
      set_req(1, 1'b0, 8'h02, 32'h0);
      for (int k = 1; k <= 11; k++) begin
         @(posedge clk); #1;
         if (k % 3 == 2) begin
            exp_p = tie_winner();
            model_apply(exp_p, 1'b0, (exp_p == 1) ? 8'h02 : 8'h01, 32'h0);
            checks++;
            if (ack_of(exp_p) !== 1'b1 || ack_of(1 - exp_p) !== 1'b0) begin
               errors++;
               $display("FAIL contend_ack_c%0d: ack1=%b ack0=%b want port %0d",
                        k, ack1, ack0, exp_p);
            end
            checks++;
            if (rdata0 !== ref_rd[0] || rdata1 !== ref_rd[1]) begin
               errors++;
               $display("FAIL contend_rdata_c%0d: rd0=%h rd1=%h want %h %h",
                        k, rdata0, rdata1, ref_rd[0], ref_rd[1]);
            end
         end else begin
            checks++;
            if (ack0 !== 1'b0 || ack1 !== 1'b0) begin
               errors++;
               $display("FAIL contend_quiet_c%0d: ack1=%b ack0=%b want 0 0",
                        k, ack1, ack0);
            end
         end
      end
      drop(0);
      drop(1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
         errors++;
         $display("FAIL contend_end: rd=%b wr=%b want 0 0", mem_read, mem_write);
      end
   endtask

   task automatic test_drop_during_access();
      run_single(1, 1'b1, 8'h20, 32'h1, 1'b1);
      run_single(1, 1'b0, 8'h20, 32'h0, 1'b0);
      checks++;
      if (rdata1 !== 32'h1) begin
         errors++;
         $display("FAIL drop_commit: rdata1=%h want 00000001", rdata1);
      end
   endtask

   task automatic test_reset_mid_access();
      logic [31:0] old;
      run_single(1, 1'b1, 8'h30, 32'hA5A5_0030, 1'b0);
      run_single(0, 1'b0, 8'h30, 32'h0, 1'b0);
      old = ref_mem[8'h30];
      @(posedge clk); #1;
      set_req(1, 1'b1, 8'h30, 32'h5);
      @(posedge clk); #1;
      checks++;
      if (mem_write !== 1'b1) begin
         errors++;
         $display("FAIL rst_pre_write: wr=%b want 1", mem_write);
      end
      #2 rst_n = 1'b0;
      #1;
      ref_rd[0] = 0; ref_rd[1] = 0; ref_lg = 1'b1;
      checks++;
      if (mem_write !== 1'b0 || mem_read !== 1'b0 || mem_addr !== 8'h0 ||
          mem_wdata !== 32'h0 || ack0 !== 1'b0 || ack1 !== 1'b0 ||
          rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
         errors++;
         $display("FAIL rst_mid: wr=%b rd=%b addr=%h wd=%h ack=%b%b r0=%h r1=%h want 0",
                  mem_write, mem_read, mem_addr, mem_wdata, ack1, ack0, rdata0, rdata1);
      end
      @(posedge clk); #1;
      checks++;
      if (tb_mem[8'h30] !== old || ack1 !== 1'b0) begin
         errors++;
         $display("FAIL rst_no_write: mem=%h ack1=%b want %h 0",
                  tb_mem[8'h30], ack1, old);
      end
      drop(1);
      @(negedge clk);
      rst_n = 1'b1;
      run_pair(1'b0, 8'h30, 32'h0, 1'b0, 8'h10, 32'h0);
   endtask

   task automatic test_idle_hold();
      run_single(1, 1'b1, 8'hFF, $urandom, 1'b0);
      run_single(0, 1'b0, 8'hFF, 32'h0, 1'b0);
      run_single(0, 1'b0, 8'hFF, 32'h0, 1'b0);
      run_single(1, 1'b0, 8'hFF, 32'h0, 1'b0);
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         checks++;
         if (mem_read !== 1'b0 || mem_write !== 1'b0 || ack0 !== 1'b0 ||
             ack1 !== 1'b0 || rdata0 !== ref_rd[0] || rdata1 !== ref_rd[1]) begin
            errors++;
            $display("FAIL idle_hold_c%0d: rd=%b wr=%b r0=%h r1=%h want 0 0 %h %h",
                     k, mem_read, mem_write, rdata0, rdata1, ref_rd[0], ref_rd[1]);
         end
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 40; it++) begin
         logic        w [2];
         logic [7:0]  a [2];
         logic [31:0] d [2];
         for (int p = 0; p < 2; p++) begin
            w[p] = $urandom_range(0, 1);
            d[p] = $urandom;
            if (w[p]) a[p] = ($urandom_range(0, 3) == 0) ? 8'(($urandom_range(0, 255))) : 8'(($urandom_range(64, 79)));
            else      a[p] = wlist[$urandom_range(0, wlist.size() - 1)];
         end
         if ($urandom_range(0, 2) == 2)
            run_pair(w[0], a[0], d[0], w[1], a[1], d[1]);
         else if ($urandom_range(0, 1) == 0)
            run_single(0, w[0], a[0], d[0], bit'($urandom_range(0, 1)));
         else
            run_single(1, w[1], a[1], d[1], bit'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_contention();
      test_drop_during_access();
      test_reset_mid_access();
      test_idle_hold();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
